// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared types and constants for the two-requester APB arbiter
// Contents: requester count, default ACCESS-phase timeout, FSM state type and
// encodings, and a helper that turns a requester index into a one-hot strobe.
package uart_apb_pkg;

    localparam int N_REQ           = 2;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    function automatic logic [N_REQ-1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_apb_arb_if.sv
// rtl/uart_apb_arb_if.sv - APB bus between the arbiter (master) and UART_REG (slave)
// Signals: PADDR/PWRITE/PWDATA/PSEL/PENABLE driven by the master,
// PRDATA/PREADY driven by the slave.
interface uart_apb_arb_if;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/uart_apb_arb_rr_arb2.sv
// rtl/uart_apb_arb_rr_arb2.sv - two-way round-robin grant with a last-grant pointer
// Ports: clk, rst_n (async, active-low); req[1:0] requests; accept commits the
// current grant; gnt[1:0] one-hot grant and gnt_idx its index (combinational).
module rr_arb2
    import uart_apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_idx
);

    // Index of the requester that wins a tie; it flips to the other side of
    // whoever was last accepted, so reset leaves requester 0 in front.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_idx = 1'b0;
        gnt     = '0;
        if (req[prio_q]) begin
            gnt_idx = prio_q;
        end else if (req[~prio_q]) begin
            gnt_idx = ~prio_q;
        end
        if (req != '0) begin
            gnt = onehot_of(gnt_idx);
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (accept && (req != '0)) begin
            prio_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/uart_apb_arb.sv
// rtl/uart_apb_arb.sv - arbitrates two requesters onto one APB master port towards UART_REG
// Ports: PCLK, PRESETn (async, active-low); req_valid/req_write/req_addr/req_wdata
// per-requester transfer requests (32-bit lanes); req_ready acceptance pulse;
// rsp_valid/rsp_rdata/rsp_err completion pulse with read data and timeout flag;
// apb master modport towards the register block.
module uart_apb_arb
    import uart_apb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_write,
    input  logic [32*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    uart_apb_arb_if.master        apb
);

    state_t            state_q,     state_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [31:0]       paddr_q,     paddr_d;
    logic [31:0]       pwdata_q,    pwdata_d;
    logic              owner_q,     owner_d;
    logic [7:0]        wait_q,      wait_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_idx;
    logic              arb_accept;

    rr_arb2 u_rr_arb2 (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .req     (req_valid),
        .accept  (arb_accept),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // State names follow the APB phase visible on the bus: the grant is
    // registered while still in IDLE, so req_ready is seen one cycle before
    // PSEL rises and IDLE must not re-arbitrate while that pulse is out.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        arb_accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ready_q != '0) begin
                    state_d = ST_SETUP;
                    psel_d  = 1'b1;
                end else if (req_valid != '0) begin
                    arb_accept  = 1'b1;
                    req_ready_d = arb_gnt;
                    owner_d     = arb_idx;
                    pwrite_d    = req_write[arb_idx];
                    paddr_d     = req_addr[{arb_idx, 5'd0} +: 32];
                    pwdata_d    = req_wdata[{arb_idx, 5'd0} +: 32];
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                wait_d    = 8'd0;
            end

            ST_ACCESS: begin
                // A ready slave wins over a counter that is about to expire.
                if (apb.PREADY) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = onehot_of(owner_q);
                    rsp_rdata_d = pwrite_q ? 32'd0 : apb.PRDATA;
                    rsp_err_d   = 1'b0;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == 8'(TIMEOUT - 1)) begin
                        state_d     = ST_RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = onehot_of(owner_q);
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            owner_q     <= 1'b0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: doc/uart_apb_arb.md
UART_APB_ARB -- requirements
Module: uart_apb_arb

Interface
REQ-001 Parameter TIMEOUT, 16, maximum ACCESS-phase cycles with PREADY low before the transfer is aborted; legal range 2..255.
REQ-002 PCLK  input  1  single clock; all state changes on rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  2  bit i: requester i presents a transfer.
REQ-005 req_write  input  2  bit i: 1 = write, 0 = read, for requester i.
REQ-006 req_addr  input  64  bits [32i+31:32i]: byte address for requester i.
REQ-007 req_wdata  input  64  bits [32i+31:32i]: write data for requester i.
REQ-008 req_ready  output  2  bit i: one-cycle pulse when requester i's transfer is accepted.
REQ-009 rsp_valid  output  2  bit i: one-cycle pulse when requester i's transfer completes.
REQ-010 rsp_rdata  output  32  read data, valid with any rsp_valid bit.
REQ-011 rsp_err  output  1  1 = timeout abort, valid with any rsp_valid bit.
REQ-012 PADDR, PWRITE, PWDATA  output  32/1/32  APB master address, direction and write data to UART_REG.
REQ-013 PSEL, PENABLE  output  1/1  APB master select and enable.
REQ-014 PRDATA, PREADY  input  32/1  APB slave read data and ready from UART_REG.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one transfer in flight.
REQ-016 IDLE: if any req_valid bit is set, grant one requester, pulse its req_ready, capture addr/write/wdata, go to SETUP.
REQ-017 Arbitration is round-robin: with both requests valid, grant the requester not granted last; after reset requester 0 has priority.
REQ-018 A request is held by the requester until req_ready; deasserting req_valid before grant withdraws it without side effect.
REQ-019 SETUP, one cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values; go to ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1, APB outputs stable; PREADY=1 ends the transfer, capture PRDATA for reads (0 for writes), rsp_err=0, go to RESP.
REQ-021 Wait counter starts at 0 on ACCESS entry and increments per PREADY-low cycle; reaching TIMEOUT aborts: PSEL/PENABLE drop next cycle, rsp_rdata=0, rsp_err=1, go to RESP.
REQ-022 PREADY=1 in the same cycle the counter reaches TIMEOUT counts as normal completion.
REQ-023 RESP, one cycle: pulse rsp_valid for the granted requester with rsp_rdata/rsp_err; go to IDLE.
REQ-024 Zero-wait transfer latency: req_ready cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3; next grant no earlier than N+4.
REQ-025 PSEL and PENABLE are low in IDLE and RESP; PENABLE is never high without PSEL.
REQ-026 All outputs are registered; no combinational path from req_* or PREADY to any output.

Reset
REQ-027 PRESETn low asynchronously forces IDLE; req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0; round-robin pointer = requester 0.
REQ-028 Reset mid-transfer discards the transfer with no rsp_valid; requesters re-issue after release.

Structure
REQ-029 Shared package uart_apb_pkg holds the FSM state typedef, the default TIMEOUT constant and the requester-count constant (2).
REQ-030 Arbitration lives in sub-module rr_arb2, a two-way round-robin grant with last-grant pointer, updated only on acceptance.

Verification
REQ-031 Req0 write addr 0x0000_0004 data 0x0000_0055, PREADY tied 1 -> req_ready[0] at N, PSEL N+1, PENABLE N+2, rsp_valid[0] N+3, rsp_err=0.
REQ-032 Req1 read addr 0x0000_0008, PREADY low 3 cycles then high with PRDATA=0x0000_00A5 -> rsp_valid[1], rsp_rdata=0xA5, rsp_err=0, APB signals stable throughout ACCESS.
REQ-033 Both req_valid held high for 4 transfers after reset -> grant order 0,1,0,1.
REQ-034 PREADY held low, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_valid with rsp_err=1 and rsp_rdata=0, PSEL low in RESP.
REQ-035 PRESETn pulsed low during ACCESS -> all outputs 0 immediately, no rsp_valid, next request after release granted to requester 0.
REQ-036 Chained with UART_REG: write then read back the same register via req0 -> rsp_rdata equals written data.
